// File: rtl/fir_coeff_load_ctrl.sv
// fir_coeff_load_ctrl: host coefficient SRAM arbitration and sequential load into the FIR coefficient bank
module fir_coeff_load_ctrl #(
  parameter int NUM_TAPS = 33,
  parameter int DATA_W = 16
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iCoeffiUpdateFlag,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [5:0]        iAddrRam,
  input  logic [DATA_W-1:0] iWrDtRam,
  input  logic [DATA_W-1:0] iRdDtRam,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [5:0]        oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic              oCoeffLd,
  output logic [5:0]        oCoeffIdx,
  output logic [DATA_W-1:0] oCoeffDt,
  output logic              oEnAcc,
  output logic              oBusy,
  output logic              oErr
);
  typedef enum logic [1:0] {IDLE, HOSTWR, LOAD, RUN} state_t;
  localparam logic [6:0] NTAPS = 7'(NUM_TAPS);
  localparam logic [5:0] LAST = 6'(NUM_TAPS - 1);
  state_t state;
  logic csnR, coeffLd, enAcc, busy, err, hostWr, badAddr;
  logic [5:0] addrR, coeffIdx;
  logic [DATA_W-1:0] dtQ;
  assign hostWr = state == HOSTWR;
  assign badAddr = {1'b0, iAddrRam} >= NTAPS;
  assign oCsnRam = hostWr ? (iCsnRam | badAddr) : csnR;
  assign oWrnRam = hostWr ? iWrnRam : 1'b1;
  assign oAddrRam = hostWr ? iAddrRam : addrR;
  assign oWrDtRam = hostWr ? iWrDtRam : '0;
  // read data arrives during the strobe cycle, so it is passed straight through and latched for holding
  assign oCoeffLd = coeffLd;
  assign oCoeffIdx = coeffIdx;
  assign oCoeffDt = coeffLd ? iRdDtRam : dtQ;
  assign oEnAcc = enAcc;
  assign oBusy = busy;
  assign oErr = err;
  always_ff @(posedge iClk_12M or posedge iRst)
    if (iRst) begin
      state <= IDLE;
      csnR <= 1'b1;
      addrR <= '0;
      coeffLd <= 1'b0;
      coeffIdx <= '0;
      dtQ <= '0;
      enAcc <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else case (state)
      IDLE: if (iCoeffiUpdateFlag) begin
        state <= HOSTWR;
        busy <= 1'b1;
        err <= 1'b0;
      end
      HOSTWR: begin
        if (badAddr && !iCsnRam) err <= 1'b1;
        if (!iCoeffiUpdateFlag) begin
          state <= LOAD;
          csnR <= 1'b0;
          addrR <= '0;
        end
      end
      LOAD: begin
        coeffLd <= !csnR;
        if (coeffLd) dtQ <= iRdDtRam;
        // csnR high inside LOAD marks the final strobe cycle with no read outstanding
        if (!csnR) begin
          coeffIdx <= addrR;
          csnR <= addrR == LAST;
          addrR <= addrR == LAST ? 6'd0 : addrR + 6'd1;
        end else begin
          state <= iCoeffiUpdateFlag ? HOSTWR : RUN;
          enAcc <= !iCoeffiUpdateFlag;
          busy <= iCoeffiUpdateFlag;
          if (iCoeffiUpdateFlag) err <= 1'b0;
        end
      end
      RUN: if (iCoeffiUpdateFlag) begin
        state <= HOSTWR;
        enAcc <= 1'b0;
        busy <= 1'b1;
        err <= 1'b0;
      end
    endcase
endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// tb_fir_coeff_load_ctrl: vector table plus scoreboarded strobe checks against a 1-cycle-latency SRAM model
module tb_fir_coeff_load_ctrl;
  logic clk = 1'b0, rst, flag, csn, wrn;
  logic [5:0] addr;
  logic [15:0] wdt, rdQ;
  logic oCsnRam, oWrnRam, oCoeffLd, oEnAcc, oBusy, oErr;
  logic [5:0] oAddrRam, oCoeffIdx;
  logic [15:0] oWrDtRam, oCoeffDt;
  logic [15:0] mem [64];
  logic [15:0] expMem [64];
  logic [21:0] q [$];
  int errors = 0, checks = 0;

  typedef struct {
    logic csn, wrn;
    logic [5:0] addr;
    logic [15:0] dt;
    logic eCsn, eWrn;
    logic [5:0] eAddr;
    logic [15:0] eDt;
    logic eErr;
  } vec_t;
  vec_t vt [6];

  fir_coeff_load_ctrl #(.NUM_TAPS(33), .DATA_W(16)) dut (
    .iClk_12M(clk), .iRst(rst), .iCoeffiUpdateFlag(flag),
    .iCsnRam(csn), .iWrnRam(wrn), .iAddrRam(addr), .iWrDtRam(wdt), .iRdDtRam(rdQ),
    .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam),
    .oCoeffLd(oCoeffLd), .oCoeffIdx(oCoeffIdx), .oCoeffDt(oCoeffDt),
    .oEnAcc(oEnAcc), .oBusy(oBusy), .oErr(oErr)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!oCsnRam) begin
      if (!oWrnRam) mem[oAddrRam] <= oWrDtRam;
      else rdQ <= mem[oAddrRam];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (oCoeffLd) begin
      if (q.size() == 0) chk("spuriousStrobe", {26'd0, oCoeffIdx}, 32'hFFFF_FFFF);
      else chk("strobe", {10'd0, oCoeffIdx, oCoeffDt}, {10'd0, q.pop_front()});
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [5:0] a, input logic [15:0] d);
    csn = c;
    wrn = w;
    addr = a;
    wdt = d;
  endtask

  task automatic pushAll;
    for (int k = 0; k < 33; k++) q.push_back({6'(k), expMem[k]});
  endtask

  task automatic waitRun(input string nm);
    int n = 0;
    while (!oEnAcc && n < 100) begin
      tick;
      n++;
    end
    chk(nm, n, 34);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 6'd3,  16'hAAAA, 1'b0, 1'b0, 6'd3,  16'hAAAA, 1'b0};
    vt[1] = '{1'b1, 1'b1, 6'd7,  16'h5555, 1'b1, 1'b1, 6'd7,  16'h5555, 1'b0};
    vt[2] = '{1'b0, 1'b1, 6'd32, 16'h0000, 1'b0, 1'b1, 6'd32, 16'h0000, 1'b0};
    vt[3] = '{1'b1, 1'b0, 6'd63, 16'h1111, 1'b1, 1'b0, 6'd63, 16'h1111, 1'b0};
    vt[4] = '{1'b0, 1'b0, 6'd33, 16'hBEEF, 1'b1, 1'b0, 6'd33, 16'hBEEF, 1'b1};
    vt[5] = '{1'b0, 1'b0, 6'd40, 16'h4040, 1'b1, 1'b0, 6'd40, 16'h4040, 1'b1};
    rst = 1'b1;
    flag = 1'b0;
    drive(1'b1, 1'b1, 6'd0, 16'd0);
    #12;
    chk("rstSram", {oCsnRam, oWrnRam, oAddrRam, oWrDtRam}, {1'b1, 1'b1, 6'd0, 16'd0});
    chk("rstCoeff", {oCoeffLd, oCoeffIdx, oCoeffDt}, 23'd0);
    chk("rstFlags", {oEnAcc, oBusy, oErr}, 3'b000);
    tick;
    rst = 1'b0;
    repeat (3) tick;
    chk("idleHold", {oEnAcc, oBusy, oCoeffLd}, 3'b000);

    flag = 1'b1;
    tick;
    chk("hostEntry", {oEnAcc, oBusy, oErr}, 3'b010);
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].csn, vt[i].wrn, vt[i].addr, vt[i].dt);
      #1;
      chk($sformatf("vecPass%0d", i), {oCsnRam, oWrnRam, oAddrRam, oWrDtRam},
          {vt[i].eCsn, vt[i].eWrn, vt[i].eAddr, vt[i].eDt});
      if (!vt[i].csn && !vt[i].wrn && vt[i].addr < 6'd33) expMem[vt[i].addr] = vt[i].dt;
      tick;
      chk($sformatf("vecErr%0d", i), oErr, vt[i].eErr);
    end
    for (int k = 0; k < 33; k++) begin
      drive(1'b0, 1'b0, 6'(k), 16'h0100 + 16'(k));
      expMem[k] = 16'h0100 + 16'(k);
      #1;
      chk("tapPass", {oCsnRam, oAddrRam}, {1'b0, 6'(k)});
      tick;
    end
    drive(1'b1, 1'b1, 6'd0, 16'd0);
    flag = 1'b0;
    pushAll;
    tick;
    chk("loadCycle0", {oBusy, oCsnRam, oWrnRam, oAddrRam}, {1'b1, 1'b0, 1'b1, 6'd0});
    waitRun("fullLoadLatency");
    chk("fullLoadDrained", q.size(), 0);
    chk("runState", {oBusy, oErr, oCsnRam, oWrnRam, oAddrRam, oWrDtRam}, {1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 16'd0});

    flag = 1'b1;
    tick;
    chk("runExit", {oEnAcc, oBusy, oErr}, 3'b010);
    drive(1'b0, 1'b0, 6'd0, 16'hFFFF);
    expMem[0] = 16'hFFFF;
    #1;
    chk("ffffPass", {oCsnRam, oWrnRam, oAddrRam, oWrDtRam}, {1'b0, 1'b0, 6'd0, 16'hFFFF});
    tick;
    drive(1'b0, 1'b0, 6'd40, 16'h1234);
    #1;
    chk("illegalCsn", oCsnRam, 1'b1);
    tick;
    chk("illegalErr", oErr, 1'b1);
    drive(1'b1, 1'b1, 6'd0, 16'd0);
    flag = 1'b0;
    pushAll;
    tick;
    repeat (10) tick;
    flag = 1'b1;
    drive(1'b0, 1'b0, 6'd5, 16'hDEAD);
    for (int i = 1; i <= 24; i++) begin
      if (i == 3) drive(1'b1, 1'b1, 6'd0, 16'd0);
      tick;
      chk("atomicLoad", {oEnAcc, oBusy}, 2'b01);
    end
    chk("reentryErrClr", oErr, 1'b0);
    chk("atomicDrained", q.size(), 0);
    drive(1'b1, 1'b1, 6'd9, 16'd0);
    #1;
    chk("directHostWr", oAddrRam, 6'd9);
    drive(1'b1, 1'b1, 6'd0, 16'd0);

    flag = 1'b0;
    pushAll;
    tick;
    repeat (5) tick;
    #1 rst = 1'b1;
    #1;
    chk("abortSram", {oCsnRam, oWrnRam, oAddrRam, oWrDtRam}, {1'b1, 1'b1, 6'd0, 16'd0});
    chk("abortCoeff", {oCoeffLd, oCoeffIdx, oCoeffDt}, 23'd0);
    chk("abortFlags", {oEnAcc, oBusy, oErr}, 3'b000);
    q.delete();
    repeat (2) tick;
    rst = 1'b0;
    repeat (5) begin
      tick;
      chk("postAbortIdle", {oEnAcc, oBusy}, 2'b00);
    end
    flag = 1'b1;
    tick;
    chk("pulseHostWr", {oEnAcc, oBusy}, 2'b01);
    flag = 1'b0;
    pushAll;
    tick;
    waitRun("pulseLoadLatency");
    chk("pulseDrained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_coeff_load_ctrl.md
FIR_COEFF_LOAD_CTRL -- requirements
Module: fir_coeff_load_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_TAPS, default 33, the number of filter taps, legal range 1..64.
REQ-002 The block SHALL have parameter DATA_W, default 16, the coefficient and SRAM data width.
REQ-003 iClk_12M  input  1  the single clock; all state changes on its rising edge.
REQ-004 iRst  input  1  reset, asynchronous and active-high.
REQ-005 iCoeffiUpdateFlag  input  1  host coefficient-update mode request, level-sensitive.
REQ-006 iCsnRam  input  1  host SRAM chip select, active-low.
REQ-007 iWrnRam  input  1  host write-not-read; 0 = write.
REQ-008 iAddrRam  input  6  host SRAM address, equal to the tap index.
REQ-009 iWrDtRam  input  DATA_W  host write data.
REQ-010 iRdDtRam  input  DATA_W  SRAM read data, valid 1 cycle after a read access.
REQ-011 oCsnRam / oWrnRam  output  1 / 1  SRAM chip select and write-not-read.
REQ-012 oAddrRam / oWrDtRam  output  6 / DATA_W  SRAM address and write data.
REQ-013 oCoeffLd  output  1  one-cycle strobe to write one coefficient-bank register.
REQ-014 oCoeffIdx / oCoeffDt  output  6 / DATA_W  tap index and coefficient value, qualified by oCoeffLd.
REQ-015 oEnAcc  output  1  filter datapath enable; 1 only while the bank holds a complete coefficient set.
REQ-016 oBusy / oErr  output  1 / 1  HOSTWR or LOAD active / sticky illegal-address flag.

Function
REQ-017 The FSM SHALL have states IDLE, HOSTWR, LOAD and RUN, all registered.
REQ-018 Transitions SHALL be as follows:
- IDLE -> HOSTWR when iCoeffiUpdateFlag=1.
- HOSTWR -> LOAD when iCoeffiUpdateFlag=0.
- LOAD -> RUN after the last strobe when the flag is 0; LOAD -> HOSTWR after the last strobe when the flag is 1.
- RUN -> HOSTWR when the flag is 1.
REQ-019 In HOSTWR, the SRAM outputs SHALL combinationally follow the host inputs, except that when iAddrRam >= NUM_TAPS:
- oCsnRam SHALL be forced to 1;
- oErr SHALL be set on the next edge if iCsnRam=0.
REQ-020 oErr SHALL be cleared on every entry into HOSTWR and SHALL otherwise hold its value.
REQ-021 Outside HOSTWR, the SRAM outputs SHALL be registered and driven by the block.
REQ-022 The LOAD sequence SHALL run as follows, with k = 0..NUM_TAPS-1:
- In LOAD cycle k, the block SHALL issue a read: oCsnRam=0, oWrnRam=1, oAddrRam=k.
- In LOAD cycle k+1, it SHALL drive oCoeffLd=1, oCoeffIdx=k and oCoeffDt=iRdDtRam.
- LOAD SHALL last exactly NUM_TAPS+1 cycles.
REQ-023 LOAD SHALL be atomic: iCoeffiUpdateFlag and the host ports SHALL be ignored until the last strobe.
REQ-024 oCoeffLd SHALL be 0 in all states except LOAD; oCoeffIdx and oCoeffDt SHALL hold their last values when oCoeffLd=0.
REQ-025 oEnAcc SHALL be 1 only in RUN, changing on the edge that enters or leaves RUN.
REQ-026 oBusy SHALL be 1 exactly in HOSTWR and LOAD.
REQ-027 The idle SRAM state (IDLE, RUN) SHALL be oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0.
REQ-028 A flag pulse of 1 cycle SHALL still produce a full HOSTWR (1 cycle) -> LOAD -> RUN pass.
REQ-029 Coefficient data SHALL pass through unmodified, with no sign extension or saturation; the index counter SHALL be 6 bits wide and SHALL never exceed NUM_TAPS-1.

Reset
REQ-030 While iRst=1, the block SHALL immediately, independent of the clock, enter IDLE and drive:
- oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0;
- oCoeffLd=0, oCoeffIdx=0, oCoeffDt=0;
- oEnAcc=0, oBusy=0, oErr=0.
REQ-031 Reset asserted mid-LOAD or mid-HOSTWR SHALL abort the operation; oEnAcc SHALL remain 0 until a later complete LOAD reaches RUN.
REQ-032 After reset deassertion, the block SHALL stay in IDLE with oEnAcc=0 until iCoeffiUpdateFlag=1.

Verification
REQ-033 The bench SHALL cover the directed scenarios below, using NUM_TAPS=33 and an SRAM model with 1-cycle read latency:
- Full load: write tap k = 16'h0100+k for k = 0..32, then drop the flag -> 33 strobes, idx 0..32 in order with matching data; then oEnAcc=1 exactly 34 cycles after the flag fell.
- Illegal address: host write to address 40 in HOSTWR -> oCsnRam stays 1, oErr=1 next cycle; oErr=0 after the next HOSTWR entry.
- Flag raised at LOAD cycle 10 -> all 33 strobes complete, then the block goes directly to HOSTWR, oEnAcc stays 0, oBusy stays 1.
- Reset at LOAD cycle 5 -> outputs at reset values immediately; no further strobes; oEnAcc=0 until a fresh load completes.
- RUN with flag raised -> oEnAcc=0 and oBusy=1 the next cycle; a host write of 16'hFFFF to address 0 passes through combinationally, and the next LOAD delivers idx 0 with data 16'hFFFF.
